// File: rtl/sram_in_arbiter.sv
// Single-port arbiter in front of the input SRAM: shares the port between the
// activation-loader writer and the L0-feed reader with round-robin on contention,
// tracks written entries and holds back reads of entries never written.
module sram_in_arbiter #(
    parameter int unsigned SRAM_BIT = 64,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DEPTH    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                wr_valid,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [SRAM_BIT-1:0] wr_data,
    output logic                wr_ready,
    input  logic                rd_valid,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_ready,
    output logic                rdata_valid,
    output logic [SRAM_BIT-1:0] rdata,
    output logic [ADDR_W:0]     fill_cnt,
    output logic                full,
    output logic                sram_CEN,
    output logic                sram_WEN,
    output logic [ADDR_W-1:0]   sram_A,
    output logic [SRAM_BIT-1:0] sram_D,
    input  logic [SRAM_BIT-1:0] sram_Q
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] written_q, written_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic             last_wr_q, last_wr_d;
    logic             rdata_valid_q;

    logic             wr_elig, rd_elig, wr_grant, rd_grant, contested, full_c;

    assign full_c = (fill_q == CNT_W'(DEPTH));

    // Eligibility and round-robin grant; nothing is granted while in reset
    always_comb begin
        wr_elig   = reset_n && wr_valid && !clear;
        rd_elig   = reset_n && rd_valid && !clear && written_q[rd_addr];
        contested = wr_elig && rd_elig;
        wr_grant  = wr_elig && (!rd_elig || !last_wr_q);
        rd_grant  = rd_elig && (!wr_elig || last_wr_q);
    end

    // SRAM port drive from the grant
    always_comb begin
        sram_CEN = 1'b1;
        sram_WEN = 1'b1;
        sram_A   = '0;
        if (wr_grant) begin
            sram_CEN = 1'b0;
            sram_WEN = 1'b0;
            sram_A   = wr_addr;
        end else if (rd_grant) begin
            sram_CEN = 1'b0;
            sram_A   = rd_addr;
        end
    end

    // Next-state for the written bitmap, fill counter and contention flag
    always_comb begin
        written_d = written_q;
        fill_d    = fill_q;
        last_wr_d = last_wr_q;
        if (contested) begin
            last_wr_d = wr_grant;
        end
        if (clear) begin
            written_d = '0;
            fill_d    = '0;
        end else if (wr_grant) begin
            written_d[wr_addr] = 1'b1;
            if (!written_q[wr_addr] && !full_c) begin
                fill_d = fill_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset drops any in-flight read response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            written_q     <= '0;
            fill_q        <= '0;
            last_wr_q     <= 1'b0;
            rdata_valid_q <= 1'b0;
        end else begin
            written_q     <= written_d;
            fill_q        <= fill_d;
            last_wr_q     <= last_wr_d;
            rdata_valid_q <= rd_grant;
        end
    end

    assign wr_ready    = wr_grant;
    assign rd_ready    = rd_grant;
    assign rdata_valid = rdata_valid_q;
    assign rdata       = sram_Q;
    assign fill_cnt    = fill_q;
    assign full        = full_c;
    assign sram_D      = wr_data;

endmodule

// File: tb/tb_sram_in_arbiter.sv
// Bench for sram_in_arbiter: cycle vector table plus directed multi-cycle sequences,
// with a behavioural single-port SRAM behind the arbiter.
module tb_sram_in_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        wr_valid;
    logic [3:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [3:0]  rd_addr;
    logic        rd_ready;
    logic        rdata_valid;
    logic [63:0] rdata;
    logic [4:0]  fill_cnt;
    logic        full;
    logic        sram_CEN;
    logic        sram_WEN;
    logic [3:0]  sram_A;
    logic [63:0] sram_D;
    logic [63:0] sram_Q;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sram_in_arbiter dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rdata_valid(rdata_valid), .rdata(rdata), .fill_cnt(fill_cnt), .full(full),
        .sram_CEN(sram_CEN), .sram_WEN(sram_WEN), .sram_A(sram_A), .sram_D(sram_D),
        .sram_Q(sram_Q)
    );

    // Behavioural SRAM: one-cycle read latency, active-low enables
    logic [63:0] mem [16];
    always @(posedge clk) begin
        if (!sram_CEN) begin
            if (!sram_WEN) mem[sram_A] <= sram_D;
            else           sram_Q      <= mem[sram_A];
        end
    end

    typedef struct {
        logic        clr, wv, rv;
        logic [3:0]  wa, ra;
        logic [63:0] wd;
        logic        e_wr, e_rd, e_rdv, e_cen, e_wen;
        logic [4:0]  e_fill;
        logic [3:0]  e_a;
        logic        chk_rd;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic clr, input logic wv, input logic [3:0] wa,
                                input logic [63:0] wd, input logic rv, input logic [3:0] ra,
                                input logic e_wr, input logic e_rd, input logic e_rdv,
                                input logic [4:0] e_fill, input logic e_cen, input logic e_wen,
                                input logic [3:0] e_a, input logic chk_rd, input logic [63:0] e_rdata);
        vec_t v;
        v.clr = clr; v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra;
        v.e_wr = e_wr; v.e_rd = e_rd; v.e_rdv = e_rdv; v.e_fill = e_fill;
        v.e_cen = e_cen; v.e_wen = e_wen; v.e_a = e_a; v.chk_rd = chk_rd; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic clr, input logic wv, input logic [3:0] wa,
                         input logic [63:0] wd, input logic rv, input logic [3:0] ra);
        clear = clr; wr_valid = wv; wr_addr = wa; wr_data = wd; rd_valid = rv; rd_addr = ra;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    localparam logic [63:0] D3 = 64'hA5A5_0000_0000_0003;

    initial begin
        // Reset state, with a write request held during reset
        reset_n = 1'b0;
        drive(1'b0, 1'b1, 4'd4, 64'h44, 1'b0, 4'd0);
        #12;
        chk("reset_cen", 64'(sram_CEN), 64'd1);
        chk("reset_wen", 64'(sram_WEN), 64'd1);
        chk("reset_wr_ready", 64'(wr_ready), 64'd0);
        chk("reset_rdv", 64'(rdata_valid), 64'd0);
        chk("reset_fill", 64'(fill_cnt), 64'd0);
        chk("reset_full", 64'(full), 64'd0);
        @(negedge clk);
        idle();
        reset_n = 1'b1;

        //          clr  wv  wa     wd      rv  ra     wr  rd  rdv fill  cen wen a     chk rdata
        vecs.push_back(mk(0, 0, 4'd0, 64'd0,  0, 4'd0, 0, 0, 0, 5'd0, 1, 1, 4'd0, 0, 64'd0));
        vecs.push_back(mk(0, 1, 4'd3, D3,     0, 4'd0, 1, 0, 0, 5'd0, 0, 0, 4'd3, 0, 64'd0));
        vecs.push_back(mk(0, 0, 4'd0, 64'd0,  1, 4'd3, 0, 1, 0, 5'd1, 0, 1, 4'd3, 0, 64'd0));
        vecs.push_back(mk(0, 0, 4'd0, 64'd0,  0, 4'd0, 0, 0, 1, 5'd1, 1, 1, 4'd0, 1, D3));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 4'd0, 64'd0, 1, 4'd7, 0, 0, 0, 5'd1, 1, 1, 4'd0, 0, 64'd0));
        vecs.push_back(mk(0, 1, 4'd7, 64'h77, 1, 4'd7, 1, 0, 0, 5'd1, 0, 0, 4'd7, 0, 64'd0));
        vecs.push_back(mk(0, 0, 4'd0, 64'd0,  1, 4'd7, 0, 1, 0, 5'd2, 0, 1, 4'd7, 0, 64'd0));
        vecs.push_back(mk(0, 0, 4'd0, 64'd0,  0, 4'd0, 0, 0, 1, 5'd2, 1, 1, 4'd0, 1, 64'h77));
        // Contested: write 8 vs read 3, alternating starting with the write
        vecs.push_back(mk(0, 1, 4'd8, 64'h88, 1, 4'd3, 1, 0, 0, 5'd2, 0, 0, 4'd8, 0, 64'd0));
        vecs.push_back(mk(0, 1, 4'd8, 64'h88, 1, 4'd3, 0, 1, 0, 5'd3, 0, 1, 4'd3, 0, 64'd0));
        vecs.push_back(mk(0, 1, 4'd8, 64'h88, 1, 4'd3, 1, 0, 1, 5'd3, 0, 0, 4'd8, 1, D3));
        vecs.push_back(mk(0, 1, 4'd8, 64'h88, 1, 4'd3, 0, 1, 0, 5'd3, 0, 1, 4'd3, 0, 64'd0));
        vecs.push_back(mk(0, 1, 4'd8, 64'h88, 1, 4'd3, 1, 0, 1, 5'd3, 0, 0, 4'd8, 1, D3));
        vecs.push_back(mk(0, 1, 4'd8, 64'h88, 1, 4'd3, 0, 1, 0, 5'd3, 0, 1, 4'd3, 0, 64'd0));
        vecs.push_back(mk(0, 0, 4'd0, 64'd0,  0, 4'd0, 0, 0, 1, 5'd3, 1, 1, 4'd0, 1, D3));

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].clr, vecs[k].wv, vecs[k].wa, vecs[k].wd, vecs[k].rv, vecs[k].ra);
            #1;
            chk($sformatf("v%0d_wr_ready", k), 64'(wr_ready), 64'(vecs[k].e_wr));
            chk($sformatf("v%0d_rd_ready", k), 64'(rd_ready), 64'(vecs[k].e_rd));
            chk($sformatf("v%0d_rdv", k), 64'(rdata_valid), 64'(vecs[k].e_rdv));
            chk($sformatf("v%0d_fill", k), 64'(fill_cnt), 64'(vecs[k].e_fill));
            chk($sformatf("v%0d_cen", k), 64'(sram_CEN), 64'(vecs[k].e_cen));
            chk($sformatf("v%0d_wen", k), 64'(sram_WEN), 64'(vecs[k].e_wen));
            chk($sformatf("v%0d_addr", k), 64'(sram_A), 64'(vecs[k].e_a));
            chk($sformatf("v%0d_sram_d", k), sram_D, vecs[k].wd);
            if (vecs[k].chk_rd) chk($sformatf("v%0d_rdata", k), rdata, vecs[k].e_rdata);
        end

        // Fill all 16 entries, rewrite one, then clear
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 4'(i), 64'h1000 + 64'(i), 1'b0, 4'd0);
            #1;
            chk($sformatf("fill_w%0d_ready", i), 64'(wr_ready), 64'd1);
            chk($sformatf("fill_w%0d_cnt", i), 64'(fill_cnt), 64'(i));
            chk($sformatf("fill_w%0d_full", i), 64'(full), 64'd0);
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd5, 64'h5555, 1'b0, 4'd0);
        #1;
        chk("full_after16", 64'(full), 64'd1);
        chk("fill_after16", 64'(fill_cnt), 64'd16);
        chk("rewrite_ready", 64'(wr_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 4'd5);
        #1;
        chk("fill_after_rewrite", 64'(fill_cnt), 64'd16);
        chk("full_after_rewrite", 64'(full), 64'd1);
        chk("read5_ready", 64'(rd_ready), 64'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, 4'd0, 64'd0, 1'b1, 4'd5);
        #1;
        chk("read5_rdv", 64'(rdata_valid), 64'd1);
        chk("read5_rdata", rdata, 64'h5555);
        chk("clear_blocks_read", 64'(rd_ready), 64'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 4'd5);
        #1;
        chk("clear_fill", 64'(fill_cnt), 64'd0);
        chk("clear_full", 64'(full), 64'd0);
        chk("clear_read_blocked", 64'(rd_ready), 64'd0);

        // Clear with a write pending: blocked that cycle, granted the next
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd2, 64'h22, 1'b0, 4'd0);
        #1;
        chk("clr_wr_ready", 64'(wr_ready), 64'd0);
        chk("clr_wr_cen", 64'(sram_CEN), 64'd1);
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("post_clr_wr_ready", 64'(wr_ready), 64'd1);
        @(negedge clk);
        idle();
        #1;
        chk("post_clr_fill", 64'(fill_cnt), 64'd1);

        // Reset right after a read grant drops the response
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 4'd2);
        #1;
        chk("rst_rd_ready", 64'(rd_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("rst_pre_rdv", 64'(rdata_valid), 64'd1);
        chk("rst_pre_rdata", rdata, 64'h22);
        reset_n = 1'b0;
        #1;
        chk("rst_rdv_dropped", 64'(rdata_valid), 64'd0);
        chk("rst_cen_idle", 64'(sram_CEN), 64'd1);
        chk("rst_wen_idle", 64'(sram_WEN), 64'd1);
        chk("rst_rd_blocked", 64'(rd_ready), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_fill", 64'(fill_cnt), 64'd0);
        chk("rst_read_blocked", 64'(rd_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("rst_read_still_blocked", 64'(rd_ready), 64'd0);
        chk("rst_no_rdv", 64'(rdata_valid), 64'd0);
        idle();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
